// File: rtl/pdm_dac_if.sv
// pdm_dac_if
//  Bundles the audio-side signals of the PDM output stage.
//  master: producer side (synth core / testbench) drives sample, valid and mute,
//          and observes pdm and muted.
//  slave : the pdm_dac itself.
//  Signals:
//   sample  WIDTH  audio word, offset binary (0 = most negative, midscale = silence)
//   valid   1      one-cycle strobe qualifying sample
//   mute    1      level: 1 = ramp to and hold midscale, 0 = play samples
//   pdm     1      PDM bitstream to the external RC filter
//   muted   1      high while the level is parked at midscale
interface pdm_dac_if #(
    parameter int WIDTH = 10
);
    logic [WIDTH-1:0] sample;
    logic             valid;
    logic             mute;
    logic             pdm;
    logic             muted;

    modport master (
        output sample,
        output valid,
        output mute,
        input  pdm,
        input  muted
    );

    modport slave (
        input  sample,
        input  valid,
        input  mute,
        output pdm,
        output muted
    );
endinterface

// File: rtl/pdm_dac.sv
// pdm_dac
//  First-order sigma-delta PDM output stage with a click-free soft-mute ramp.
//  The level register walks toward midscale (mute) or the latest sample (unmute)
//  in RAMP_STEP increments, and the accumulator carry becomes the output bit.
//  The modulator advances once every CLK_DIV clk_i cycles.
//  Ports:
//   clk_i   in   system clock
//   rst_ni  in   asynchronous active-low reset
//   bus     slave modport of pdm_dac_if (sample/valid/mute in, pdm/muted out)
module pdm_dac #(
    parameter int WIDTH     = 10,
    parameter int CLK_DIV   = 1,
    parameter int RAMP_STEP = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    pdm_dac_if.slave   bus
);
    localparam logic [WIDTH-1:0] MID       = {1'b1, {(WIDTH-1){1'b0}}};
    localparam int               DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [WIDTH-1:0] STEP      = WIDTH'(RAMP_STEP);
    localparam logic [WIDTH:0]   STEP_EXT  = (WIDTH+1)'(RAMP_STEP);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_RAMP,
        ST_MUTED
    } state_t;

    logic [DIV_W-1:0] div_cnt_reg;
    logic [WIDTH-1:0] smp_reg;
    logic [WIDTH-1:0] lvl_reg;
    logic [WIDTH-1:0] lvl_next;
    logic [WIDTH-1:0] acc_reg;
    logic             pdm_reg;
    logic             muted_reg;
    state_t           state_reg;
    state_t           state_next;

    logic                    mod_tick;
    logic [WIDTH-1:0]        target;
    logic signed [WIDTH:0]   diff;
    logic [WIDTH:0]          diff_mag;
    logic                    ramp_done;
    logic [WIDTH-1:0]        ramp_lvl;
    logic [WIDTH:0]          sum;

    assign mod_tick = (div_cnt_reg == DIV_LAST);
    assign target   = bus.mute ? MID : smp_reg;

    // Signed distance to the target; one extra bit covers the full +/- range.
    assign diff      = $signed({1'b0, target}) - $signed({1'b0, lvl_reg});
    assign diff_mag  = diff[WIDTH] ? (-diff) : diff;
    assign ramp_done = (diff_mag <= STEP_EXT);

    // Snap once within one step so the level never overshoots the target,
    // which also keeps it inside the unsigned range.
    always_comb begin
        ramp_lvl = target;
        if (!ramp_done) begin
            ramp_lvl = diff[WIDTH] ? (lvl_reg - STEP) : (lvl_reg + STEP);
        end
    end

    // Next-state / next-level logic; only committed on mod_tick.
    always_comb begin
        state_next = state_reg;
        lvl_next   = lvl_reg;
        case (state_reg)
            ST_RUN: begin
                if (!bus.mute) begin
                    lvl_next = smp_reg;
                end else begin
                    // Entering the ramp takes its first step on this same tick.
                    lvl_next   = ramp_lvl;
                    state_next = ramp_done ? ST_MUTED : ST_RAMP;
                end
            end
            ST_RAMP: begin
                lvl_next = ramp_lvl;
                if (ramp_done) begin
                    state_next = bus.mute ? ST_MUTED : ST_RUN;
                end
            end
            ST_MUTED: begin
                if (!bus.mute) begin
                    lvl_next   = ramp_lvl;
                    state_next = ramp_done ? ST_RUN : ST_RAMP;
                end else begin
                    lvl_next = MID;
                end
            end
            default: begin
                state_next = ST_RUN;
                lvl_next   = MID;
            end
        endcase
    end

    // The modulator integrates the level from before this tick's update,
    // giving a one-tick pipeline between lvl and pdm.
    assign sum = {1'b0, acc_reg} + {1'b0, lvl_reg};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt_reg <= '0;
            smp_reg     <= MID;
            lvl_reg     <= MID;
            acc_reg     <= '0;
            state_reg   <= ST_RUN;
            pdm_reg     <= 1'b0;
            muted_reg   <= 1'b0;
        end else begin
            div_cnt_reg <= mod_tick ? '0 : (div_cnt_reg + 1'b1);
            if (bus.valid) begin
                smp_reg <= bus.sample;
            end
            if (mod_tick) begin
                lvl_reg   <= lvl_next;
                acc_reg   <= sum[WIDTH-1:0];
                pdm_reg   <= sum[WIDTH];
                state_reg <= state_next;
                muted_reg <= (state_next == ST_MUTED);
            end
        end
    end

    assign bus.pdm   = pdm_reg;
    assign bus.muted = muted_reg;
endmodule

// File: tb/tb_pdm_dac.sv
// tb_pdm_dac
//  Self-checking bench for pdm_dac. dut1 runs at CLK_DIV=1, dut4 at CLK_DIV=4.
//  Expected output bits come from an integer accumulator fed with the level
//  trajectory each test derives from the ramp rules; they are queued when the
//  stimulus is applied and popped when the edge has produced the DUT output.
module tb_pdm_dac;
    localparam int WIDTH = 10;
    localparam int FULL  = 1 << WIDTH;
    localparam int MID   = FULL / 2;

    logic clk = 1'b0;
    logic rst_n;
    logic rst4_n;

    always #5 clk = ~clk;

    pdm_dac_if #(.WIDTH(WIDTH)) bus1 ();
    pdm_dac_if #(.WIDTH(WIDTH)) bus4 ();

    pdm_dac #(.WIDTH(WIDTH), .CLK_DIV(1), .RAMP_STEP(8)) dut1 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus1)
    );

    pdm_dac #(.WIDTH(WIDTH), .CLK_DIV(4), .RAMP_STEP(8)) dut4 (
        .clk_i  (clk),
        .rst_ni (rst4_n),
        .bus    (bus4)
    );

    typedef struct {
        logic pdm;
        logic muted;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_acc;
    int   m_lvl;
    int   ones_cnt;

    // One modulator tick on dut1. lvl_after / muted_after are the level and
    // muted flag expected once this edge has been taken.
    task automatic drive(input logic v, input int s, input logic m,
                         input int lvl_after, input logic muted_after,
                         input string tag);
        exp_t e;
        int   sum;
        bus1.valid  = v;
        bus1.sample = s[WIDTH-1:0];
        bus1.mute   = m;
        sum     = m_acc + m_lvl;
        e.pdm   = (sum >= FULL);
        e.muted = muted_after;
        m_acc   = sum % FULL;
        m_lvl   = lvl_after;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        bus1.valid = 1'b0;
        e = sb_q.pop_front();
        n_tests++;
        if (bus1.pdm !== e.pdm || bus1.muted !== e.muted) begin
            n_fail++;
            $display("FAIL %s: got pdm=%b muted=%b, expected pdm=%b muted=%b (lvl model %0d)",
                     tag, bus1.pdm, bus1.muted, e.pdm, e.muted, lvl_after);
        end
        if (bus1.pdm === 1'b1) ones_cnt++;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        rst4_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (bus1.pdm !== 1'b0) begin n_fail++; $display("FAIL reset_pdm1: got %b, expected 0", bus1.pdm); end
        n_tests++;
        if (bus1.muted !== 1'b0) begin n_fail++; $display("FAIL reset_muted1: got %b, expected 0", bus1.muted); end
        n_tests++;
        if (bus4.pdm !== 1'b0) begin n_fail++; $display("FAIL reset_pdm4: got %b, expected 0", bus4.pdm); end
        n_tests++;
        if (bus4.muted !== 1'b0) begin n_fail++; $display("FAIL reset_muted4: got %b, expected 0", bus4.muted); end
        @(negedge clk);
        rst_n = 1'b1;
        m_acc = 0;
        m_lvl = MID;
        $display("[TB] reset: outputs checked, dut1 released");
    endtask

    task automatic test_midscale();
        drive(1'b1, MID, 1'b0, MID, 1'b0, "midscale");
        for (int i = 0; i < 15; i++) drive(1'b0, MID, 1'b0, MID, 1'b0, "midscale");
        $display("[TB] midscale: sample 512, 16 ticks checked");
    endtask

    task automatic test_levels();
        // Sample 0: previous sample still feeds lvl on the first edge.
        drive(1'b1, 0, 1'b0, MID, 1'b0, "level0");
        for (int i = 0; i < 2049; i++) drive(1'b0, 0, 1'b0, 0, 1'b0, "level0");
        $display("[TB] level 0: 2050 ticks checked");

        drive(1'b1, 1023, 1'b0, 0, 1'b0, "level1023");
        drive(1'b0, 0, 1'b0, 1023, 1'b0, "level1023");
        drive(1'b0, 0, 1'b0, 1023, 1'b0, "level1023");
        ones_cnt = 0;
        for (int i = 0; i < FULL; i++) drive(1'b0, 0, 1'b0, 1023, 1'b0, "level1023");
        n_tests++;
        if (ones_cnt !== 1023) begin n_fail++; $display("FAIL density1023: got %0d ones, expected 1023", ones_cnt); end
        $display("[TB] level 1023: %0d ones in 1024 ticks", ones_cnt);

        drive(1'b1, 256, 1'b0, 1023, 1'b0, "level256");
        drive(1'b0, 0, 1'b0, 256, 1'b0, "level256");
        drive(1'b0, 0, 1'b0, 256, 1'b0, "level256");
        ones_cnt = 0;
        for (int i = 0; i < FULL; i++) drive(1'b0, 0, 1'b0, 256, 1'b0, "level256");
        n_tests++;
        if (ones_cnt !== 256) begin n_fail++; $display("FAIL density256: got %0d ones, expected 256", ones_cnt); end
        $display("[TB] level 256: %0d ones in 1024 ticks", ones_cnt);
    endtask

    task automatic test_mute_ramp();
        drive(1'b1, 1023, 1'b0, 256, 1'b0, "mute_setup");
        drive(1'b0, 0, 1'b0, 1023, 1'b0, "mute_setup");
        drive(1'b0, 0, 1'b0, 1023, 1'b0, "mute_setup");
        for (int k = 1; k <= 63; k++) drive(1'b0, 0, 1'b1, 1023 - 8 * k, 1'b0, "mute_ramp");
        drive(1'b0, 0, 1'b1, MID, 1'b1, "mute_snap");
        for (int i = 0; i < 8; i++) drive(1'b0, 0, 1'b1, MID, 1'b1, "mute_hold");
        $display("[TB] mute: 1023 -> 512 in 64 ticks, muted held");
    endtask

    task automatic test_unmute_reverse();
        for (int k = 1; k <= 63; k++) drive(1'b0, 0, 1'b0, MID + 8 * k, 1'b0, "unmute_ramp");
        drive(1'b0, 0, 1'b0, 1023, 1'b0, "unmute_snap");
        drive(1'b0, 0, 1'b0, 1023, 1'b0, "unmute_run");
        for (int k = 1; k <= 32; k++) drive(1'b0, 0, 1'b1, 1023 - 8 * k, 1'b0, "partial_mute");
        for (int j = 1; j <= 32; j++) drive(1'b0, 0, 1'b0, 767 + 8 * j, 1'b0, "reverse_ramp");
        // Back in RUN: a new sample is taken directly rather than ramped to.
        drive(1'b1, 256, 1'b0, 1023, 1'b0, "reverse_run");
        for (int i = 0; i < 4; i++) drive(1'b0, 0, 1'b0, 256, 1'b0, "reverse_run");
        $display("[TB] unmute/reverse: ramp reversed at 767, returned to RUN");
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clk);
        bus1.valid  = 1'b1;
        bus1.sample = 10'(700);
        rst_n       = 1'b0;
        #1;
        n_tests++;
        if (bus1.pdm !== 1'b0 || bus1.muted !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_async: got pdm=%b muted=%b, expected 0/0", tag, bus1.pdm, bus1.muted);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (bus1.pdm !== 1'b0 || bus1.muted !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_held: got pdm=%b muted=%b, expected 0/0", tag, bus1.pdm, bus1.muted);
        end
        @(negedge clk);
        bus1.valid = 1'b0;
        bus1.mute  = 1'b0;
        rst_n      = 1'b1;
        m_acc      = 0;
        m_lvl      = MID;
        // Sample register must be back at MID, so lvl stays at MID.
        for (int i = 0; i < 4; i++) drive(1'b0, 0, 1'b0, MID, 1'b0, "post_reset");
        drive(1'b1, 256, 1'b0, MID, 1'b0, "post_reset_sample");
        for (int i = 0; i < 6; i++) drive(1'b0, 0, 1'b0, 256, 1'b0, "post_reset_sample");
        $display("[TB] %s: reset cleared outputs, first sample accepted", tag);
    endtask

    task automatic test_reset_mid_ramp();
        // Currently RUN at 256; mute ramps upward toward 512.
        for (int k = 1; k <= 10; k++) drive(1'b0, 0, 1'b1, 256 + 8 * k, 1'b0, "pre_reset_ramp");
        pulse_reset("reset_mid_ramp");
        for (int k = 1; k <= 31; k++) drive(1'b0, 0, 1'b1, 256 + 8 * k, 1'b0, "pre_reset_mute");
        drive(1'b0, 0, 1'b1, MID, 1'b1, "pre_reset_mute");
        drive(1'b0, 0, 1'b1, MID, 1'b1, "pre_reset_mute");
        pulse_reset("reset_while_muted");
    endtask

    task automatic test_clkdiv();
        exp_t e;
        int   acc4 = 0;
        int   lvl4 = MID;
        int   smp4 = MID;
        int   cnt4 = 0;
        logic pdm4 = 1'b0;
        int   sum;
        @(negedge clk);
        rst4_n = 1'b1;
        for (int ed = 1; ed <= 64; ed++) begin
            bus4.valid  = (ed == 1) || (ed == 30);
            bus4.sample = (ed == 30) ? 10'(1023) : 10'(MID);
            if (cnt4 == 3) begin
                sum  = acc4 + lvl4;
                pdm4 = (sum >= FULL);
                acc4 = sum % FULL;
                lvl4 = smp4;
            end
            if (bus4.valid) smp4 = int'(bus4.sample);
            cnt4 = (cnt4 + 1) % 4;
            e.pdm   = pdm4;
            e.muted = 1'b0;
            sb_q.push_back(e);
            @(posedge clk);
            #1;
            bus4.valid = 1'b0;
            e = sb_q.pop_front();
            n_tests++;
            if (bus4.pdm !== e.pdm || bus4.muted !== e.muted) begin
                n_fail++;
                $display("FAIL clkdiv edge %0d: got pdm=%b muted=%b, expected pdm=%b muted=%b",
                         ed, bus4.pdm, bus4.muted, e.pdm, e.muted);
            end
        end
        $display("[TB] clkdiv4: 64 edges checked, mid-interval sample captured");
    endtask

    initial begin
        bus1.valid  = 1'b0;
        bus1.sample = '0;
        bus1.mute   = 1'b0;
        bus4.valid  = 1'b0;
        bus4.sample = '0;
        bus4.mute   = 1'b0;
        ones_cnt    = 0;
        test_reset();
        test_midscale();
        test_levels();
        test_mute_ramp();
        test_unmute_reverse();
        test_reset_mid_ramp();
        test_clkdiv();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
